// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 write controller: command opcodes,
// sequencer states, the bus word record and the init-list ROM.
package lt24_pkg;

  localparam logic [7:0] CMD_SLEEPOUT = 8'h11;
  localparam logic [7:0] CMD_MADCTL   = 8'h36;
  localparam logic [7:0] CMD_COLMOD   = 8'h3A;
  localparam logic [7:0] CMD_DISPON   = 8'h29;
  localparam logic [7:0] CMD_CASET    = 8'h2A;
  localparam logic [7:0] CMD_PASET    = 8'h2B;
  localparam logic [7:0] CMD_RAMWR    = 8'h2C;

  localparam logic [7:0] COLMOD_RGB565 = 8'h55;

  // Number of bus writes in the init list and in a window-set sequence.
  localparam int INIT_LEN = 5;
  localparam int WIN_LEN  = 11;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_SLEEPOUT,
    ST_SLEEP_WAIT,
    ST_INIT_CMDS,
    ST_IDLE,
    ST_WINDOW,
    ST_PIXEL
  } seq_state_e;

  // One 8080 bus transfer: rs=0 command, rs=1 data/payload.
  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } bus_word_t;

  // Init list issued after sleep-out: MADCTL, COLMOD (RGB565), display on.
  function automatic bus_word_t init_rom(input logic [3:0] idx, input logic [7:0] madctl);
    bus_word_t w;
    case (idx)
      4'd0:    w = '{rs: 1'b0, data: {8'h00, CMD_MADCTL}};
      4'd1:    w = '{rs: 1'b1, data: {8'h00, madctl}};
      4'd2:    w = '{rs: 1'b0, data: {8'h00, CMD_COLMOD}};
      4'd3:    w = '{rs: 1'b1, data: {8'h00, COLMOD_RGB565}};
      default: w = '{rs: 1'b0, data: {8'h00, CMD_DISPON}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lt24_bus_writer.sv
// Single 8080-style bus write engine. A start drives rs/data with Wr_n low
// for WR_LOW_CYCLES, then Wr_n high for WR_HIGH_CYCLES with rs/data held so
// the panel latches on the rising edge. done pulses in the last high cycle,
// and a start in that same cycle chains the next write with no gap.
module lt24_bus_writer
  import lt24_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int WR_HIGH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  bus_word_t   word,
  output logic        wr_n,
  output logic        rs,
  output logic [15:0] data,
  output logic        done
);

  logic        busy;
  logic        high_phase;
  logic [15:0] cnt;

  assign done = busy && high_phase && (cnt == 16'(WR_HIGH_CYCLES - 1));

  // Strobe timing: low phase count, then high phase count, data held throughout.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n       <= 1'b1;
      rs         <= 1'b0;
      data       <= 16'h0000;
      busy       <= 1'b0;
      high_phase <= 1'b0;
      cnt        <= 16'h0000;
    end else if (start && (!busy || done)) begin
      wr_n       <= 1'b0;
      rs         <= word.rs;
      data       <= word.data;
      busy       <= 1'b1;
      high_phase <= 1'b0;
      cnt        <= 16'h0000;
    end else if (busy) begin
      if (!high_phase) begin
        if (cnt == 16'(WR_LOW_CYCLES - 1)) begin
          wr_n       <= 1'b1;
          high_phase <= 1'b1;
          cnt        <= 16'h0000;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (cnt == 16'(WR_HIGH_CYCLES - 1)) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/lt24_write_controller.sv
// LT24 panel write controller: power-on reset and init sequence, then a
// pixel stream over valid/ready. A window (CASET/PASET/RAMWR) is only sent
// when the pixel is not where the panel's auto-increment would put it.
module lt24_write_controller
  import lt24_pkg::*;
#(
  parameter int         WIDTH             = 240,
  parameter int         HEIGHT            = 320,
  parameter int         WR_LOW_CYCLES     = 1,
  parameter int         WR_HIGH_CYCLES    = 1,
  parameter int         RESET_HOLD_CYCLES = 500000,
  parameter int         RESET_WAIT_CYCLES = 6000000,
  parameter int         SLEEP_WAIT_CYCLES = 6000000,
  parameter logic [7:0] MADCTL_VALUE      = 8'h40
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic [7:0]  pixelX,
  input  logic [8:0]  pixelY,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        ready,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic        LT24Reset_n,
  output logic [15:0] LT24Data,
  output logic        LT24LCDOn
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  seq_state_e  state, state_nxt;
  logic [31:0] wait_cnt;
  logic [3:0]  idx;
  logic        start, done, accept, hit;
  bus_word_t   word;

  logic [7:0]  x_q;
  logic [8:0]  y_q;
  logic [15:0] data_q;

  // Window record: where the panel's write pointer wraps to, and where it
  // will be after the last pixel written.
  logic [7:0]  win_x_min, next_x;
  logic [8:0]  win_y_min, next_y;
  logic        win_valid;

  assign LT24Rd_n = 1'b1;

  // Window-set word i: CASET x..WIDTH-1, PASET y..HEIGHT-1, then RAMWR.
  function automatic bus_word_t win_word(input logic [3:0] i, input logic [7:0] x,
                                         input logic [8:0] y);
    bus_word_t   w;
    logic [15:0] yz, hl;
    yz = {7'h00, y};
    hl = {7'h00, Y_LAST};
    case (i)
      4'd0:    w = '{rs: 1'b0, data: {8'h00, CMD_CASET}};
      4'd1:    w = '{rs: 1'b1, data: 16'h0000};
      4'd2:    w = '{rs: 1'b1, data: {8'h00, x}};
      4'd3:    w = '{rs: 1'b1, data: 16'h0000};
      4'd4:    w = '{rs: 1'b1, data: {8'h00, X_LAST}};
      4'd5:    w = '{rs: 1'b0, data: {8'h00, CMD_PASET}};
      4'd6:    w = '{rs: 1'b1, data: {8'h00, yz[15:8]}};
      4'd7:    w = '{rs: 1'b1, data: {8'h00, yz[7:0]}};
      4'd8:    w = '{rs: 1'b1, data: {8'h00, hl[15:8]}};
      4'd9:    w = '{rs: 1'b1, data: {8'h00, hl[7:0]}};
      default: w = '{rs: 1'b0, data: {8'h00, CMD_RAMWR}};
    endcase
    return w;
  endfunction

  lt24_bus_writer #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_writer (
    .clk  (clock),
    .rst  (globalReset),
    .start(start),
    .word (word),
    .wr_n (LT24Wr_n),
    .rs   (LT24RS),
    .data (LT24Data),
    .done (done)
  );

  // Sequencer next state and the bus word to launch; a new write is always
  // launched in the cycle the previous one reports done.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    word      = '{rs: 1'b0, data: 16'h0000};
    accept    = 1'b0;
    hit       = win_valid && (pixelX == next_x) && (pixelY == next_y);
    case (state)
      ST_RST_HOLD:
        if (wait_cnt == 32'(RESET_HOLD_CYCLES - 1)) state_nxt = ST_RST_WAIT;
      ST_RST_WAIT:
        if (wait_cnt == 32'(RESET_WAIT_CYCLES - 1)) begin
          state_nxt = ST_SLEEPOUT;
          start     = 1'b1;
          word      = '{rs: 1'b0, data: {8'h00, CMD_SLEEPOUT}};
        end
      ST_SLEEPOUT:
        if (done) state_nxt = ST_SLEEP_WAIT;
      ST_SLEEP_WAIT:
        if (wait_cnt == 32'(SLEEP_WAIT_CYCLES - 1)) begin
          state_nxt = ST_INIT_CMDS;
          start     = 1'b1;
          word      = init_rom(4'd0, MADCTL_VALUE);
        end
      ST_INIT_CMDS:
        if (done) begin
          if (idx == 4'(INIT_LEN - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            start = 1'b1;
            word  = init_rom(idx + 4'd1, MADCTL_VALUE);
          end
        end
      ST_IDLE:
        if (pixelWrite && pixelReady) begin
          accept = 1'b1;
          start  = 1'b1;
          if (hit) begin
            state_nxt = ST_PIXEL;
            word      = '{rs: 1'b1, data: pixelData};
          end else begin
            state_nxt = ST_WINDOW;
            word      = win_word(4'd0, pixelX, pixelY);
          end
        end
      ST_WINDOW:
        if (done) begin
          start = 1'b1;
          if (idx == 4'(WIN_LEN - 1)) begin
            state_nxt = ST_PIXEL;
            word      = '{rs: 1'b1, data: data_q};
          end else begin
            word = win_word(idx + 4'd1, x_q, y_q);
          end
        end
      ST_PIXEL:
        if (done) state_nxt = ST_IDLE;
      default: state_nxt = ST_RST_HOLD;
    endcase
  end

  // State, counters, registered pin outputs and window prediction.
  always_ff @(posedge clock) begin
    if (globalReset) begin
      state       <= ST_RST_HOLD;
      wait_cnt    <= 32'd0;
      idx         <= 4'd0;
      pixelReady  <= 1'b0;
      ready       <= 1'b0;
      LT24LCDOn   <= 1'b0;
      LT24Reset_n <= 1'b0;
      LT24CS_n    <= 1'b1;
      x_q         <= 8'h00;
      y_q         <= 9'h000;
      data_q      <= 16'h0000;
      win_x_min   <= 8'h00;
      win_y_min   <= 9'h000;
      next_x      <= 8'h00;
      next_y      <= 9'h000;
      win_valid   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) wait_cnt <= 32'd0;
      else                    wait_cnt <= wait_cnt + 32'd1;

      if (start) idx <= (state_nxt == state) ? idx + 4'd1 : 4'd0;

      pixelReady  <= (state_nxt == ST_IDLE);
      LT24Reset_n <= (state_nxt != ST_RST_HOLD);
      LT24CS_n    <= !(state_nxt == ST_SLEEPOUT || state_nxt == ST_INIT_CMDS ||
                       state_nxt == ST_WINDOW   || state_nxt == ST_PIXEL);
      if (state_nxt == ST_IDLE) begin
        ready     <= 1'b1;
        LT24LCDOn <= 1'b1;
      end

      if (accept) begin
        x_q    <= pixelX;
        y_q    <= pixelY;
        data_q <= pixelData;
        if (!hit) begin
          win_x_min <= pixelX;
          win_y_min <= pixelY;
          next_x    <= pixelX;
          next_y    <= pixelY;
          win_valid <= 1'b1;
        end
      end

      // Follow the panel's auto-increment: column wraps to the window's
      // left edge, row wraps to the window's top after the last row.
      if (state == ST_PIXEL && done) begin
        if (next_x == X_LAST) begin
          next_x <= win_x_min;
          next_y <= (next_y == Y_LAST) ? win_y_min : next_y + 9'd1;
        end else begin
          next_x <= next_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lt24_write_controller.sv
// Bench for lt24_write_controller: a transaction-level model predicts the
// bus write list and the status outputs; a monitor checks every cycle.
module tb_lt24_write_controller;

  localparam int W        = 240;
  localparam int H        = 320;
  localparam int HOLD     = 4;
  localparam int WAITC    = 3;
  localparam int SLEEP    = 3;
  localparam int WCYC     = 2;
  localparam int INIT_CYC = HOLD + WAITC + WCYC + SLEEP + 5 * WCYC;

  logic        clock = 1'b0;
  logic        globalReset = 1'b1;
  logic [7:0]  pixelX = '0;
  logic [8:0]  pixelY = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady, ready, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
  logic [15:0] LT24Data;

  always #5 clock = ~clock;

  lt24_write_controller #(
    .WIDTH(W), .HEIGHT(H), .WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(1),
    .RESET_HOLD_CYCLES(HOLD), .RESET_WAIT_CYCLES(WAITC), .SLEEP_WAIT_CYCLES(SLEEP),
    .MADCTL_VALUE(8'h40)
  ) dut (
    .clock(clock), .globalReset(globalReset), .pixelX(pixelX), .pixelY(pixelY),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady), .ready(ready),
    .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS),
    .LT24Reset_n(LT24Reset_n), .LT24Data(LT24Data), .LT24LCDOn(LT24LCDOn)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit          started = 0;
  bit          m_rst = 0;
  int          k = 0;
  int          busy = 0;
  bit          wv = 0;
  int          wx, wy, nx, ny;
  logic [16:0] exq[$];
  logic [16:0] obs[$];

  task automatic model_pixel(input int x, input int y, input logic [15:0] d);
    if (!(wv && x == nx && y == ny)) begin
      exq.push_back({1'b0, 16'h002A}); exq.push_back({1'b1, 16'h0000});
      exq.push_back({1'b1, 16'(x)});   exq.push_back({1'b1, 16'h0000});
      exq.push_back({1'b1, 16'(W - 1)});
      exq.push_back({1'b0, 16'h002B}); exq.push_back({1'b1, 16'(y / 256)});
      exq.push_back({1'b1, 16'(y % 256)});
      exq.push_back({1'b1, 16'((H - 1) / 256)}); exq.push_back({1'b1, 16'((H - 1) % 256)});
      exq.push_back({1'b0, 16'h002C});
      wv = 1; wx = x; wy = y; nx = x; ny = y;
      busy = 12 * WCYC;
    end else begin
      busy = WCYC;
    end
    exq.push_back({1'b1, d});
    if (nx == W - 1) begin
      nx = wx;
      ny = (ny == H - 1) ? wy : ny + 1;
    end else begin
      nx = nx + 1;
    end
  endtask

  // Model update on each active edge, from the bench-driven inputs only.
  always @(posedge clock) begin
    m_rst = globalReset;
    if (globalReset) begin
      started = 1; k = 0; busy = 0; wv = 0;
      exq.delete();
      exq.push_back({1'b0, 16'h0011}); exq.push_back({1'b0, 16'h0036});
      exq.push_back({1'b1, 16'h0040}); exq.push_back({1'b0, 16'h003A});
      exq.push_back({1'b1, 16'h0055}); exq.push_back({1'b0, 16'h0029});
    end else if (started) begin
      bit pr;
      pr = (k >= INIT_CYC) && (busy == 0);
      if (k < INIT_CYC) k++;
      if (busy > 0) busy--;
      if (pr && pixelWrite) model_pixel(int'(pixelX), int'(pixelY), pixelData);
    end
  end

  // ---------------- compare / bus monitor ----------------
  logic        prev_wr = 1'b1;
  int          low_len = 0;
  logic [16:0] cur = '0;

  always @(negedge clock) begin
    if (started) begin
      if (m_rst) begin
        chk("reset_outputs",
            32'({LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn, pixelReady, ready, LT24Data}),
            32'({8'b1110_0000, 16'h0000}));
        prev_wr = 1'b1;
      end else begin
        bit pr;
        pr = (k >= INIT_CYC) && (busy == 0);
        chk("status", 32'({LT24Rd_n, LT24Reset_n, ready, LT24LCDOn, pixelReady}),
            32'({1'b1, k >= HOLD, k >= INIT_CYC, k >= INIT_CYC, pr}));
        if (pr) chk("cs_idle", 32'(LT24CS_n), 32'(1));
        if (LT24Wr_n == 1'b0) begin
          chk("cs_in_write", 32'(LT24CS_n), 32'(0));
          if (prev_wr) begin
            cur = {LT24RS, LT24Data};
            low_len = 1;
          end else begin
            low_len++;
            chk("low_stable", 32'({LT24RS, LT24Data}), 32'(cur));
          end
        end else if (prev_wr == 1'b0) begin
          chk("low_len", 32'(low_len), 32'(1));
          chk("rise_stable", 32'({LT24RS, LT24Data}), 32'(cur));
          obs.push_back(cur);
          if (exq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL write_unexpected: got %0h expected none", cur);
          end else begin
            chk("write", 32'(cur), 32'(exq.pop_front()));
          end
        end
        prev_wr = LT24Wr_n;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present a pixel and hold pixelWrite until it is taken; returns on the
  // falling edge after the accepting clock edge.
  task automatic send_px(input int x, input int y, input logic [15:0] d);
    bit got;
    got = 0;
    pixelX = 8'(x); pixelY = 9'(y); pixelData = d; pixelWrite = 1'b1;
    for (int i = 0; i < 400; i++) begin
      got = (pixelReady === 1'b1);
      @(negedge clock);
      if (got) break;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) never accepted", x, y);
    end
  endtask

  task automatic idle(input int n);
    pixelWrite = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  logic [16:0] init_exp[6] = '{17'h00011, 17'h00036, 17'h10040, 17'h0003A, 17'h10055, 17'h00029};
  logic [16:0] win_exp[12] = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h100EF, 17'h0002B,
                               17'h10000, 17'h10014, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};

  initial begin
    int ncmd;
    @(negedge clock); @(negedge clock);
    globalReset = 1'b0;
    obs.delete();
    repeat (7) @(negedge clock);
    chk("sleepout_launch", 32'({LT24Wr_n, LT24RS, LT24Data}), 32'(18'h00011));
    repeat (14) @(negedge clock);
    chk("ready_early", 32'(ready), 32'(0));
    @(negedge clock);
    chk("ready_lcd_pr", 32'({ready, LT24LCDOn, pixelReady}), 32'(3'b111));
    @(negedge clock);
    chk("init_count", 32'(obs.size()), 32'(6));
    foreach (init_exp[i]) if (i < obs.size()) chk("init_word", 32'(obs[i]), 32'(init_exp[i]));

    // First pixel: full window then the colour.
    obs.delete();
    send_px(10, 20, 16'hF800);
    idle(30);
    chk("win1_count", 32'(obs.size()), 32'(12));
    foreach (win_exp[i]) if (i < obs.size()) chk("win1_word", 32'(obs[i]), 32'(win_exp[i]));

    // Next pixel in sequence: single data write, ready back in 3 clocks.
    obs.delete();
    send_px(11, 20, 16'h07E0);
    pixelWrite = 1'b0;
    chk("pr_c1", 32'(pixelReady), 32'(0));
    @(negedge clock); chk("pr_c2", 32'(pixelReady), 32'(0));
    @(negedge clock); chk("pr_c3", 32'(pixelReady), 32'(1));
    idle(5);
    chk("stream1_count", 32'(obs.size()), 32'(1));
    if (obs.size() > 0) chk("stream1_word", 32'(obs[0]), 32'(17'h107E0));

    // Stream to the right edge, then wrap to column 10 of the next row.
    obs.delete();
    for (int x = 12; x <= 239; x++) send_px(x, 20, 16'(x * 3));
    send_px(10, 21, 16'h1234);
    idle(10);
    ncmd = 0;
    foreach (obs[i]) if (!obs[i][16]) ncmd++;
    chk("row_stream_count", 32'(obs.size()), 32'(229));
    chk("row_stream_cmds", 32'(ncmd), 32'(0));

    // Off-prediction pixel at column 0: full window with x payload 00.
    obs.delete();
    send_px(0, 21, 16'hABCD);
    idle(30);
    chk("win2_count", 32'(obs.size()), 32'(12));
    if (obs.size() == 12) begin
      chk("win2_x", 32'(obs[2]), 32'(17'h10000));
      chk("win2_y", 32'(obs[7]), 32'(17'h10015));
      chk("win2_px", 32'(obs[11]), 32'(17'h1ABCD));
    end

    // Bottom-right corner: row 319 wraps back to the window's top row.
    obs.delete();
    send_px(230, 318, 16'h0001);
    for (int x = 231; x <= 239; x++) send_px(x, 318, 16'(x));
    for (int x = 230; x <= 239; x++) send_px(x, 319, 16'(x + 1000));
    send_px(230, 318, 16'hBEEF);
    idle(30);
    ncmd = 0;
    foreach (obs[i]) if (!obs[i][16]) ncmd++;
    chk("corner_count", 32'(obs.size()), 32'(32));
    chk("corner_cmds", 32'(ncmd), 32'(3));
    if (obs.size() == 32) chk("corner_last", 32'(obs[31]), 32'(17'h1BEEF));

    // Reset in the middle of the PASET payload.
    obs.delete();
    send_px(5, 100, 16'h5555);
    pixelWrite = 1'b0;
    repeat (12) @(negedge clock);
    chk("paset_low", 32'({LT24Wr_n, LT24RS, LT24Data}), 32'(18'h10000));
    globalReset = 1'b1;
    obs.delete();
    @(negedge clock);
    chk("midreset_pins", 32'({LT24CS_n, LT24Wr_n, LT24Reset_n, pixelReady, ready}), 32'(5'b11000));
    @(negedge clock);
    globalReset = 1'b0;
    send_px(10, 20, 16'h0F0F);
    idle(40);
    chk("replay_count", 32'(obs.size()), 32'(18));
    if (obs.size() == 18) begin
      chk("replay_first", 32'(obs[0]), 32'(17'h00011));
      chk("replay_caset", 32'(obs[6]), 32'(17'h0002A));
      chk("replay_px", 32'(obs[17]), 32'(17'h10F0F));
    end

    chk("queue_drained", 32'(exq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
